alu_nibble_sequencer: RTL
=========================

Name: alu_nibble_sequencer

Overview:
- Upstream/downstream controller for the team's 4-bit 74181-style ALU slice.
- Accepts a wide operation (NIBBLES*4 bits) and drives the slice one nibble per cycle, LSB first.
- Ripples the carry between nibbles through a register and assembles the wide result.
- Lets a single slice instance execute 16-bit (default) arithmetic and logic ops.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operation (W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_s  input  4  function select, passed to slice unchanged.
- op_m  input  1  mode: 1 = logic, 0 = arithmetic.
- op_ci  input  1  carry-in, slice convention, active-low (1 = no carry).
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and cout valid.
- result  output  W  assembled result; holds until next accepted start.
- cout  output  1  final carry, active-low (0 = carry out of MSB nibble).
- alu_s  output  4  to slice s.
- alu_m  output  1  to slice M.
- alu_ci  output  1  to slice ci.
- alu_a  output  4  to slice a.
- alu_b  output  4  to slice b.
- alu_y  input  4  from slice y.
- alu_co  input  1  from slice carry-out, active-low.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state = IDLE, nibble index = 0, carry_q = 1, operand regs = 0. busy = 0, done = 0, result = 0, cout = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge: latch op_s, op_m, op_a, op_b; set carry_q = op_ci, idx = 0; go to RUN.
  - start = 0: remain in IDLE.
- RUN:
  - Combinational slice drive: alu_a = a_q[4*idx+3:4*idx], alu_b = b_q[4*idx+3:4*idx], alu_s = s_q, alu_m = m_q, alu_ci = carry_q.
  - Each edge: result[4*idx+3:4*idx] <= alu_y; carry_q <= alu_co; idx <= idx+1.
  - When idx == NIBBLES-1 at the edge: go to DONE.
- DONE:
  - done = 1; cout = carry_q (registered on the RUN->DONE edge); next edge to IDLE.
- Outside RUN, slice drive is idle: alu_a = 0, alu_b = 0, alu_s = 0, alu_m = 1, alu_ci = 1.
- Latency: start sampled at edge 0; done high in the cycle after edge NIBBLES; throughput one op per NIBBLES+2 cycles.
- Handshake:
  - start while busy or in DONE is ignored; it is not queued.
  - Operand inputs may change freely after the accepting edge.
- Mode handling: in logic mode (M = 1) carry is still rippled mechanically; cout is then don't-care but must be deterministic (last alu_co).
- result is updated nibble-by-nibble during RUN; it is only guaranteed valid when done = 1.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse; partial result discarded.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds output zero (1 bit), registered with done; high when the full W-bit result == 0.
  - Adds output ovf (1 bit): XOR of the carry into and out of the MSB nibble's top bit. The sequencer computes it from the MSB-nibble operands, op_s = 1001 add only; 0 otherwise.
  - Both reset to 0 and hold until the next done.
- Undefined: ports absent, no extra logic.

Test Plan:
- Reset: rst_n low then high -> busy = 0, done = 0, result = 0x0000, cout = 1, alu_m = 1, alu_ci = 1.
- Add: A = 0x1234, B = 0x4321, s = 1001, M = 0, ci = 1, one start pulse -> busy for 4 cycles, alu_a sequence 4, 3, 2, 1, done in cycle 5 with result = 0x5555, cout = 1.
- Carry ripple: A = 0xFFFF, B = 0x0001, s = 1001, M = 0, ci = 1 -> alu_ci sequence 1, 0, 0, 0; result = 0x0000, cout = 0. With ALU_SEQ_FLAGS_EN: zero = 1, ovf = 0.
- Logic pass-through: A = 0xA5C3, B = 0x3C3C, s = 1111, M = 1, ci = 0 -> result = 0xA5C3; a repeated start during busy is ignored (exactly one done pulse).
- Reset mid-op: start the add above, drop rst_n after 2 RUN cycles -> outputs return to reset values at once; no done; next op completes normally.
- Back-to-back: start held high continuously -> ops accepted every 6 cycles (NIBBLES+2); each done pulse carries the matching result.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit 74181-style ALU slice one nibble per cycle (LSB first) to execute a W-bit op.
// Optional zero/ovf flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_ci,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                   zero,
    output logic                   ovf,
`endif
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_ci,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    input  logic [3:0]             alu_y,
    input  logic                   alu_co
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [3:0]         s_q;
    logic               m_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               last_nib;

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational slice drive; the slice sees a benign idle pattern outside RUN
    always_comb begin
        state_d = state_q;
        alu_s   = 4'b0000;
        alu_m   = 1'b1;
        alu_ci  = 1'b1;
        alu_a   = 4'b0000;
        alu_b   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_s  = s_q;
                alu_m  = m_q;
                alu_ci = carry_q;
                alu_a  = a_q[{idx_q, 2'b00} +: 4];
                alu_b  = b_q[{idx_q, 2'b00} +: 4];
                if (last_nib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, carry ripple and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b1;
            s_q     <= 4'b0000;
            m_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            cout    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q     <= op_s;
                        m_q     <= op_m;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= op_ci;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    result[{idx_q, 2'b00} +: 4] <= alu_y;
                    carry_q <= alu_co;
                    idx_q   <= last_nib ? '0 : idx_q + IDX_W'(1);
                    if (last_nib) begin
                        cout <= alu_co;
`ifdef ALU_SEQ_FLAGS_EN
                        // Top nibble is still in flight, so splice it in for the zero test
                        zero <= ({alu_y, result[W-5:0]} == '0);
                        ovf  <= (!m_q && (s_q == 4'b1001))
                              ? ((a_q[W-1] ~^ b_q[W-1]) & (alu_y[3] ^ a_q[W-1]))
                              : 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
